fifo_uart_tx: RTL

Serial transmit stage that drains bytes from the upstream first-word-fall-through `fifo` and shifts each one out as an 8N1 UART frame on a single pin. It sits directly downstream of the FIFO, consuming its `empty`/`read_data` outputs and driving its `read_en`. Back-to-back bytes are sent with no idle gap while the FIFO stays non-empty.

---
 rtl/fifo_uart_tx_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 36 +++
 rtl/fifo_uart_tx.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: frame geometry, transmitter state encoding and the default bit period.
// Kept separate so a future receiver can reuse the same constants.
package fifo_uart_tx_pkg;

    localparam int unsigned UartDataBits      = 8;
    localparam int unsigned DefaultClksPerBit = 868;
    localparam int unsigned BitIdxW           = $clog2(UartDataBits);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A synchronous clear restarts the period, e.g. when a new frame begins.
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter fed from a first-word-fall-through FIFO.
// Pops the next byte in the last stop-bit cycle so consecutive frames abut with no idle gap.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [UartDataBits-1:0] fifo_read_data,
    output logic                    fifo_read_en,
    output logic                    tx,
    output logic                    busy
);

    localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(UartDataBits - 1);

    uart_tx_state_e          state_q, state_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic [BitIdxW-1:0]      bit_idx_q, bit_idx_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    baud_tick;
    logic                    baud_clear;

    assign fifo_read_en = !reset && !fifo_empty &&
                          ((state_q == StIdle) || ((state_q == StStop) && baud_tick));

    // Idle holds the counter at zero so the start bit gets a full period after a pop.
    assign baud_clear = fifo_read_en || (state_q == StIdle);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        if (fifo_read_en) begin
            state_d   = StStart;
            shift_d   = fifo_read_data;
            bit_idx_d = '0;
            tx_d      = 1'b0;
        end else if (baud_tick) begin
            case (state_q)
                StStart: begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
                StData: begin
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
